// File: rtl/cmd_mem_responder.sv
// cmd_mem_responder: block-RAM command responder that emulates an SDRAM controller's
// init delay, cmdReady back-pressure and fixed-latency in-order read returns.
module cmd_mem_responder #(
   parameter int AddrWidth   = 8,
   parameter int DataWidth   = 8,
   parameter int InitCycles  = 16,
   parameter int ReadLatency = 3,
   parameter int StallEvery  = 0,
   parameter int StallCycles = 2
) (
   input  logic                 clk,
   input  logic                 rst,
   output logic                 cmdReady,
   input  logic                 cmdTrigger,
   input  logic [AddrWidth-1:0] cmdAddr,
   input  logic                 cmdWrite,
   input  logic [DataWidth-1:0] cmdWriteData,
   output logic [DataWidth-1:0] cmdReadData,
   output logic                 cmdReadDataValid
);
   localparam int CW = $clog2((InitCycles > StallCycles ? InitCycles : StallCycles) + 1);
   localparam int AW = StallEvery > 0 ? $clog2(StallEvery + 1) : 1;
   typedef enum logic [1:0] {INIT, READY, STALL} state_t;
   state_t state, state_d;
   logic [CW-1:0] cnt, cnt_d;
   logic [AW-1:0] acc, acc_d;
   logic [DataWidth-1:0] mem [2**AddrWidth] = '{default: '0};
   logic [ReadLatency-1:0] vld;
   logic [DataWidth-1:0] dat [ReadLatency];
   logic accept;
   assign accept = cmdReady & cmdTrigger;
   assign cmdReadDataValid = vld[ReadLatency-1];
   assign cmdReadData = dat[ReadLatency-1];
   always_comb begin
      state_d = state;
      cnt_d = cnt;
      acc_d = acc;
      case (state)
         INIT, STALL: begin
            state_d = cnt == '0 ? READY : state;
            cnt_d = cnt == '0 ? cnt : cnt - 1'b1;
         end
         READY:
            if (StallEvery > 0 && accept) begin
               state_d = acc == AW'(StallEvery - 1) ? STALL : READY;
               cnt_d = CW'(StallCycles - 1);
               acc_d = acc == AW'(StallEvery - 1) ? '0 : acc + 1'b1;
            end
         default: state_d = INIT;
      endcase
   end
   always_ff @(posedge clk) begin
      if (rst) begin
         state <= INIT;
         cnt <= CW'(InitCycles - 1);
         acc <= '0;
         cmdReady <= 1'b0;
         vld <= '0;
         for (int i = 0; i < ReadLatency; i++) dat[i] <= '0;
      end else begin
         state <= state_d;
         cnt <= cnt_d;
         acc <= acc_d;
         cmdReady <= state_d == READY;
         vld[0] <= accept & ~cmdWrite;
         if (accept && !cmdWrite) dat[0] <= mem[cmdAddr];
         // data stages only move with a valid word so the output holds between returns
         for (int i = 1; i < ReadLatency; i++) begin
            vld[i] <= vld[i-1];
            if (vld[i-1]) dat[i] <= dat[i-1];
         end
      end
   end
   always_ff @(posedge clk)
      if (!rst && accept && cmdWrite) mem[cmdAddr] <= cmdWriteData;
endmodule

// File: tb/tb_cmd_mem_responder.sv
// tb_cmd_mem_responder: directed table and sequence checks on three responders
// (no stalls, stall every 3, stall every 5) sharing one clock and reset.
module tb_cmd_mem_responder;
   logic clk = 1'b0;
   logic rst = 1'b1;
   logic trig [3], wr [3], rdy [3], rv [3];
   logic [7:0] addr [3], wdat [3], rd [3];
   int checks = 0, fails = 0, cyc = 0;
   logic [7:0] q0 [$], q1 [$], q2 [$];
   int t0 [$];
   typedef struct {
      logic w;
      logic [7:0] a, d, e;
   } vec_t;
   vec_t vec [11];

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   for (genvar g = 0; g < 3; g++) begin : g_dut
      cmd_mem_responder #(.StallEvery(g == 0 ? 0 : (g == 1 ? 3 : 5))) u_dut (
         .clk(clk), .rst(rst), .cmdReady(rdy[g]), .cmdTrigger(trig[g]), .cmdAddr(addr[g]),
         .cmdWrite(wr[g]), .cmdWriteData(wdat[g]), .cmdReadData(rd[g]), .cmdReadDataValid(rv[g])
      );
   end

   always @(negedge clk) begin
      if (rv[0]) begin
         q0.push_back(rd[0]);
         t0.push_back(cyc);
      end
      if (rv[1]) q1.push_back(rd[1]);
      if (rv[2]) q2.push_back(rd[2]);
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic check(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         fails++;
         $display("FAIL %s: got 'h%0h, expected 'h%0h", name, act, exp);
      end
   endtask

   // present a command, wait for the accepting edge, then drop the trigger
   task automatic issue(input int k, input logic w, input logic [7:0] a, input logic [7:0] d,
                        output int n, output int ac);
      wr[k] = w;
      addr[k] = a;
      wdat[k] = d;
      trig[k] = 1'b1;
      n = 0;
      while (!rdy[k] && n < 100) begin
         @(negedge clk);
         n++;
      end
      if (!rdy[k]) check("issue_timeout", n, -1);
      ac = cyc;
      @(negedge clk);
      trig[k] = 1'b0;
   endtask

   task automatic idle(input int c);
      repeat (c) @(negedge clk);
   endtask

   initial begin
      int n, ac, c0, na;
      logic [7:0] ea [$];
      int et [$];
      logic [15:0] lfsr;
      logic [24:0] pat, epat;
      logic [7:0] e;
      for (int k = 0; k < 3; k++) begin
         trig[k] = 1'b0;
         wr[k] = 1'b0;
         addr[k] = '0;
         wdat[k] = '0;
      end
      vec[0]  = '{1'b1, 8'h5A, 8'hA5, 8'h00};
      vec[1]  = '{1'b0, 8'h5A, 8'h00, 8'hA5};
      vec[2]  = '{1'b1, 8'h00, 8'h11, 8'h00};
      vec[3]  = '{1'b1, 8'hFF, 8'h22, 8'h00};
      vec[4]  = '{1'b0, 8'h00, 8'h00, 8'h11};
      vec[5]  = '{1'b0, 8'hFF, 8'h00, 8'h22};
      vec[6]  = '{1'b1, 8'h5A, 8'h3C, 8'h00};
      vec[7]  = '{1'b0, 8'h5A, 8'h00, 8'h3C};
      vec[8]  = '{1'b0, 8'h01, 8'h00, 8'h00};
      vec[9]  = '{1'b1, 8'h80, 8'h7F, 8'h00};
      vec[10] = '{1'b0, 8'h80, 8'h00, 8'h7F};
      idle(2);
      check("reset_ready", rdy[0], 0);
      check("reset_valid", rv[0], 0);
      check("reset_data", rd[0], 0);
      check("reset_ready_stall", rdy[1], 0);
      rst = 1'b0;
      issue(0, 1'b0, 8'h00, 8'h00, n, ac);
      check("init_low_cycles", n, 16);
      idle(8);
      check("init_read_count", q0.size(), 1);
      if (q0.size() > 0) begin
         check("init_read_data", q0[0], 0);
         check("init_read_latency", t0[0] - ac, 3);
      end
      q0.delete();
      t0.delete();
      for (int i = 0; i < 11; i++) begin
         issue(0, vec[i].w, vec[i].a, vec[i].d, n, ac);
         if (!vec[i].w) begin
            ea.push_back(vec[i].e);
            et.push_back(ac + 3);
         end
      end
      idle(8);
      check("table_count", q0.size(), ea.size());
      for (int i = 0; i < ea.size() && i < q0.size(); i++) begin
         check("table_data", q0[i], ea[i]);
         check("table_latency", t0[i], et[i]);
      end
      for (int a = 16; a < 20; a++) issue(0, 1'b1, 8'(a), ~8'(a), n, ac);
      q0.delete();
      t0.delete();
      check("pipe_ready", rdy[0], 1);
      wr[0] = 1'b0;
      addr[0] = 8'h10;
      trig[0] = 1'b1;
      c0 = cyc;
      for (int i = 1; i < 4; i++) begin
         @(negedge clk);
         addr[0] = 8'h10 + 8'(i);
      end
      @(negedge clk);
      trig[0] = 1'b0;
      idle(8);
      check("pipe_count", q0.size(), 4);
      for (int i = 0; i < 4 && i < q0.size(); i++) begin
         check("pipe_data", q0[i], 8'hEF - i);
         check("pipe_cycle", t0[i], c0 + 3 + i);
      end
      q0.delete();
      t0.delete();
      wr[0] = 1'b0;
      addr[0] = 8'h5A;
      trig[0] = 1'b1;
      @(negedge clk);
      addr[0] = 8'h80;
      @(negedge clk);
      trig[0] = 1'b0;
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      check("midreset_ready", rdy[0], 0);
      check("midreset_valid", rv[0], 0);
      issue(0, 1'b0, 8'h5A, 8'h00, n, ac);
      check("reinit_low_cycles", n, 16);
      check("midreset_flush", q0.size(), 0);
      issue(0, 1'b0, 8'h80, 8'h00, n, ac);
      issue(0, 1'b0, 8'h10, 8'h00, n, ac);
      idle(8);
      check("retain_count", q0.size(), 3);
      if (q0.size() == 3) begin
         check("retain_5a", q0[0], 8'h3C);
         check("retain_80", q0[1], 8'h7F);
         check("retain_10", q0[2], 8'hEF);
      end
      na = 0;
      wr[1] = 1'b1;
      addr[1] = 8'h40;
      wdat[1] = 8'h55;
      trig[1] = 1'b1;
      for (int j = 0; j < 25; j++) begin
         pat[j] = rdy[1];
         epat[j] = (j % 5) < 3;
         if (rdy[1]) na++;
         @(negedge clk);
         addr[1] = 8'h40 + 8'(na);
         wdat[1] = 8'h55 ^ 8'(na);
      end
      trig[1] = 1'b0;
      check("stall_pattern", int'(pat), int'(epat));
      check("stall_accepts", na, 15);
      q1.delete();
      for (int k = 0; k < 16; k++) issue(1, 1'b0, 8'h40 + 8'(k), 8'h00, n, ac);
      idle(8);
      check("stall_read_count", q1.size(), 16);
      for (int k = 0; k < 16 && k < q1.size(); k++)
         check("stall_read_data", q1[k], k < 15 ? (8'h55 ^ k) : 0);
      for (int a = 0; a < 256; a++) issue(2, 1'b1, 8'(a), ~8'(a), n, ac);
      q2.delete();
      ea.delete();
      lfsr = 16'hACE1;
      for (int i = 0; i < 300; i++) begin
         lfsr = {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
         if (lfsr[0]) issue(2, 1'b1, lfsr[15:8], ~lfsr[15:8], n, ac);
         else begin
            issue(2, 1'b0, lfsr[15:8], 8'h00, n, ac);
            ea.push_back(lfsr[15:8]);
         end
      end
      idle(10);
      check("soak_count", q2.size(), ea.size());
      for (int i = 0; i < ea.size() && i < q2.size(); i++) begin
         e = ~ea[i];
         check("soak_data", q2[i], e);
      end
      $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
      $finish;
   end
endmodule
